delay_dn: RTL and testbench
===========================

DELAY_DN -- requirements
Module: delay_dn

Interface
REQ-001 Parameter FLUX, default 2, number of independent data fluxes (FLUX >= 2).
REQ-002 Parameter DATA_WIDTH, default 18, payload bits per token.
REQ-003 Parameter DELAY, default 8, delay in tokens per flux (DELAY >= 1).
REQ-004 Parameter INIT_VALUE, default 0, DATA_WIDTH-bit value emitted before a flux has filled.
REQ-005 Derived: TAG_WIDTH = $clog2(FLUX); WIDTH = DATA_WIDTH + TAG_WIDTH.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock; all state changes on the rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 read_port_in_pel  read_interface.actor  empty[FLUX] in, read[FLUX] out, dout[WIDTH] in; input token stream.
REQ-010 write_port_out_pel  write_interface.actor  full[FLUX] in, write out, din[WIDTH] out; output token stream, din = {tag, data}.

Function
REQ-011 Flux i is eligible when empty[i]==0 and full[i]==0 and rst==0.
REQ-012 At most one flux fires per cycle; the selected flux is g.
REQ-013 Firing is single-cycle and combinational: same cycle read[g]=1, write=1, din={g[TAG_WIDTH-1:0], out_g}; read[j]=0 for all j != g.
REQ-014 No eligible flux: write=0, all read bits 0, din don't-care, no state change.
REQ-015 Per flux, a circular buffer of DELAY entries, a pointer ptr[i] (0..DELAY-1), and a fill counter fill[i] (0..DELAY, saturating).
REQ-016 out_g = INIT_VALUE when fill[g] < DELAY, otherwise buf[g][ptr[g]] (read before write).
REQ-017 On firing: buf[g][ptr[g]] <= dout[DATA_WIDTH-1:0]; ptr[g] <= (ptr[g]==DELAY-1) ? 0 : ptr[g]+1; fill[g] increments, saturating at DELAY.
REQ-018 Input tag bits dout[WIDTH-1:DATA_WIDTH] are ignored; the flux is identified by the empty/read lane.
REQ-019 Net behaviour: the n-th output token of flux i equals its (n-DELAY)-th input token, or INIT_VALUE for n < DELAY.
REQ-020 Fluxes are fully independent; firing one never alters the pointer, fill or buffer of another.
REQ-021 DELAY=1 with INIT_VALUE=0 gives a one-token delay with a defined first output of 0.

Reset
REQ-022 While rst=1: read all 0, write=0, no buffer writes.
REQ-023 On a clock edge with rst=1: all ptr=0, all fill=0, arbiter pointer=0; buffer contents are not cleared (masked by fill).
REQ-024 Reset asserted mid-stream discards all history; the next DELAY outputs per flux are INIT_VALUE.

Configuration
REQ-025 Macro DELAY_DN_RR_EN defined: round-robin selection; search starts at last_grant+1 mod FLUX; last_grant <= g on firing; reset value FLUX-1, so flux 0 is searched first.
REQ-026 Macro DELAY_DN_RR_EN undefined: fixed priority; lowest eligible index wins; no arbiter state.

Structure
REQ-027 Shared package delay_pkg holds the default DATA_WIDTH, a tag-width function, and the INIT_VALUE default.
REQ-028 Storage is one ram_dual_ported instance of depth FLUX*DELAY, width DATA_WIDTH, asynchronous read; address = g*DELAY + ptr[g].
REQ-029 Selection logic is a sub-module flux_arbiter (eligibility vector in, one-hot grant plus index out, round-robin state under DELAY_DN_RR_EN).

Verification
REQ-030 FLUX=2, DELAY=3, flux0 inputs 1,2,3,4,5, output never full -> flux0 outputs 0,0,0,1,2 with tag 0.
REQ-031 Flux0 and flux1 interleaved, inputs 10,20,30 and 11,21,31 with DELAY=1 -> outputs 0,10,20 on tag 0 and 0,11,21 on tag 1; no cross-flux mixing.
REQ-032 full[0]=1 with flux0 non-empty -> read[0]=0, write=0 for flux0 and ptr/fill unchanged; after full[0] drops, the sequence resumes without loss.
REQ-033 With DELAY_DN_RR_EN, both fluxes continuously eligible -> grants alternate 0,1,0,1; without the macro -> grants are always 0.
REQ-034 DELAY=3, after 5 tokens on flux0 assert rst for 1 cycle, then send 7,8,9,6 -> outputs 0,0,0,7.
REQ-035 DELAY=4, 10 tokens 1..10 on flux1 -> outputs 0,0,0,0,1,2,3,4,5,6; checks pointer wrap and fill saturation.

Source files
------------

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
// delay_pkg : shared defaults and tag-width helper for the delay_dn slice
// Rev 1.0
// ============================================================================
package delay_pkg;

   localparam int DEFAULT_DATA_WIDTH = 18;
   localparam int DEFAULT_INIT_VALUE = 0;

   // Number of bits needed to carry a flux index; at least one bit.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flux_arbiter.sv
`default_nettype none
// ============================================================================
// flux_arbiter : picks one eligible flux; round-robin when DELAY_DN_RR_EN,
//                otherwise lowest index wins.  Rev 1.0
// ============================================================================
module flux_arbiter
   import delay_pkg::*;
#(
   parameter int FLUX  = 2,
   localparam int IDX_W = tag_width(FLUX)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FLUX-1:0]  elig_i,
   output logic [FLUX-1:0]  grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] w_idx;

   assign valid_o = |elig_i;

`ifdef DELAY_DN_RR_EN
   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] last_d;
   logic             w_found;
   int               w_cand;

   // Search begins one past the previous winner and wraps around.
   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      w_cand  = 0;
      for (int k = 1; k <= FLUX; k++) begin
         w_cand = (int'(last_q) + k) % FLUX;
         if (!w_found && elig_i[w_cand]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(w_cand);
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (valid_o) begin
         last_d = w_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= IDX_W'(FLUX - 1);
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   always_comb begin
      w_idx = '0;
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (elig_i[i]) begin
            w_idx = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      grant_o = '0;
      if (valid_o) begin
         grant_o[w_idx] = 1'b1;
      end
   end

   assign idx_o = w_idx;

endmodule
`default_nettype wire

// File: rtl/ram_dual_ported.sv
`default_nettype none
// ============================================================================
// ram_dual_ported : one synchronous write port, one asynchronous read port
// Rev 1.0
// ============================================================================
module ram_dual_ported #(
   parameter int DEPTH  = 16,
   parameter int WIDTH  = 18,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/delay_dn.sv
`default_nettype none
// ============================================================================
// delay_dn : FLUX independent DELAY-token delay lines over one shared RAM.
//            Option macro: DELAY_DN_RR_EN (round-robin flux selection). Rev 1.0
// ============================================================================
module delay_dn
   import delay_pkg::*;
#(
   parameter int                    FLUX       = 2,
   parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int                    DELAY      = 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEFAULT_INIT_VALUE),
   localparam int                   TAG_WIDTH  = tag_width(FLUX),
   localparam int                   WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FLUX-1:0]  read_port_in_pel_empty_i,
   output logic [FLUX-1:0]  read_port_in_pel_read_o,
   input  logic [WIDTH-1:0] read_port_in_pel_dout_i,
   input  logic [FLUX-1:0]  write_port_out_pel_full_i,
   output logic             write_port_out_pel_write_o,
   output logic [WIDTH-1:0] write_port_out_pel_din_o
);

   localparam int DEPTH  = FLUX * DELAY;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W  = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam int FILL_W = $clog2(DELAY + 1);

   localparam logic [PTR_W-1:0]  C_PTR_LAST = PTR_W'(DELAY - 1);
   localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(DELAY);
   localparam logic [ADDR_W-1:0] C_DELAY_A  = ADDR_W'(DELAY);

   logic [PTR_W-1:0]  ptr_q  [FLUX];
   logic [PTR_W-1:0]  ptr_d  [FLUX];
   logic [FILL_W-1:0] fill_q [FLUX];
   logic [FILL_W-1:0] fill_d [FLUX];

   logic [FLUX-1:0]       w_elig;
   logic [FLUX-1:0]       w_grant;
   logic [TAG_WIDTH-1:0]  w_idx;
   logic                  w_fire;
   logic [PTR_W-1:0]      w_ptr_g;
   logic [FILL_W-1:0]     w_fill_g;
   logic [ADDR_W-1:0]     w_addr;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] w_out;

   // Upstream tag bits carry no meaning here; the lane identifies the flux.
   logic [TAG_WIDTH-1:0] unused_in_tag;
   assign unused_in_tag = read_port_in_pel_dout_i[WIDTH-1:DATA_WIDTH];

   assign w_elig = ~read_port_in_pel_empty_i & ~write_port_out_pel_full_i & {FLUX{~rst}};

   flux_arbiter #(
      .FLUX (FLUX)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .elig_i  (w_elig),
      .grant_o (w_grant),
      .idx_o   (w_idx),
      .valid_o (w_fire)
   );

   assign w_ptr_g  = ptr_q[w_idx];
   assign w_fill_g = fill_q[w_idx];
   assign w_addr   = ADDR_W'(w_idx) * C_DELAY_A + ADDR_W'(w_ptr_g);

   ram_dual_ported #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_fire),
      .waddr_i (w_addr),
      .wdata_i (read_port_in_pel_dout_i[DATA_WIDTH-1:0]),
      .raddr_i (w_addr),
      .rdata_o (w_rdata)
   );

   // Stale RAM contents stay hidden until the flux has seen DELAY tokens.
   assign w_out = (w_fill_g == C_FILL_MAX) ? w_rdata : INIT_VALUE;

   always_comb begin
      for (int i = 0; i < FLUX; i++) begin
         ptr_d[i]  = ptr_q[i];
         fill_d[i] = fill_q[i];
      end
      if (w_fire) begin
         ptr_d[w_idx]  = (w_ptr_g == C_PTR_LAST) ? '0 : w_ptr_g + 1'b1;
         fill_d[w_idx] = (w_fill_g == C_FILL_MAX) ? w_fill_g : w_fill_g + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FLUX; i++) begin
            ptr_q[i]  <= '0;
            fill_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FLUX; i++) begin
            ptr_q[i]  <= ptr_d[i];
            fill_q[i] <= fill_d[i];
         end
      end
   end

   assign read_port_in_pel_read_o    = w_grant;
   assign write_port_out_pel_write_o = w_fire;
   assign write_port_out_pel_din_o   = {w_idx, w_out};

endmodule
`default_nettype wire

// File: tb/tb_delay_dn.sv
`default_nettype none
// ============================================================================
// tb_delay_dn : scoreboard bench for delay_dn (FLUX=2, DELAY=3), directed
//               scenarios followed by randomized traffic. Rev 1.0
// ============================================================================
module tb_delay_dn;

   localparam int FLUX  = 2;
   localparam int DW    = 18;
   localparam int DELAY = 3;
   localparam int TW    = 1;
   localparam int W     = DW + TW;
   localparam logic [DW-1:0] INIT = '0;
   localparam int LOGN  = 4096;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [FLUX-1:0] empty;
   logic [FLUX-1:0] rd;
   logic [W-1:0]    dout;
   logic [FLUX-1:0] full;
   logic            wr;
   logic [W-1:0]    din;

   int checks = 0;
   int errors = 0;

   exp_t            sb_q [$];
   logic [DW-1:0]   in_log [FLUX][LOGN];
   int              n_in [FLUX];
   int              last_g;

   always #5 clk = ~clk;

   delay_dn #(
      .FLUX       (FLUX),
      .DATA_WIDTH (DW),
      .DELAY      (DELAY),
      .INIT_VALUE (INIT)
   ) u_dut (
      .clk                        (clk),
      .rst                        (rst),
      .read_port_in_pel_empty_i   (empty),
      .read_port_in_pel_read_o    (rd),
      .read_port_in_pel_dout_i    (dout),
      .write_port_out_pel_full_i  (full),
      .write_port_out_pel_write_o (wr),
      .write_port_out_pel_din_o   (din)
   );

   // Reference selection rule, independent of the DUT's internals.
   function automatic int predict(input logic [FLUX-1:0] el);
      int c;
      if (el == '0) return -1;
`ifdef DELAY_DN_RR_EN
      for (int k = 1; k <= FLUX; k++) begin
         c = (last_g + k) % FLUX;
         if (el[c]) return c;
      end
      return -1;
`else
      c = 0;
      while (!el[c]) c++;
      return c;
`endif
   endfunction

   task automatic model_reset();
      for (int f = 0; f < FLUX; f++) n_in[f] = 0;
      last_g = FLUX - 1;
   endtask

   // One clock of stimulus; the expected output is queued for the monitor.
   task automatic cycle(input bit r, input logic [FLUX-1:0] e, input logic [FLUX-1:0] f,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      int   g;
      exp_t x;
      logic [DW-1:0] d;
      @(posedge clk);
      #1;
      rst   = r;
      empty = e;
      full  = f;
      if (r) begin
         model_reset();
         g = -1;
      end else begin
         g = predict(~e & ~f);
      end
      if (g >= 0) begin
         d      = (g == 0) ? d0 : d1;
         dout   = {TW'($urandom), d};
         x.tag  = TW'(g);
         x.data = (n_in[g] < DELAY) ? INIT : in_log[g][n_in[g] - DELAY];
         if (n_in[g] < LOGN) begin
            in_log[g][n_in[g]] = d;
            n_in[g]++;
         end
         last_g = g;
         sb_q.push_back(x);
      end else begin
         dout = W'($urandom);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   bit mon_en = 1'b0;
   initial begin
      exp_t          x;
      logic [FLUX-1:0] oh;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            checks++;
            if (wr) begin
               if (sb_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write: din=%h read=%b, required no write", din, rd);
               end else begin
                  x  = sb_q.pop_front();
                  oh = '0;
                  oh[x.tag] = 1'b1;
                  if (din !== {x.tag, x.data} || rd !== oh) begin
                     errors++;
                     $display("FAIL token: din=%h read=%b, required din=%h read=%b",
                              din, rd, {x.tag, x.data}, oh);
                  end
               end
            end else begin
               if (sb_q.size() != 0 || rd !== '0) begin
                  errors++;
                  $display("FAIL missing_write: write=%b read=%b pending=%0d, required a write",
                           wr, rd, sb_q.size());
                  if (sb_q.size() != 0) void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      empty = '1;
      full  = '0;
      dout  = '0;
      model_reset();

      // Reset held with every lane eligible: nothing may fire.
      cycle(1, 2'b00, 2'b00, 18'd50, 18'd51);
      mon_en = 1'b1;
      cycle(1, 2'b00, 2'b00, 18'd52, 18'd53);

      // Flux 0 alone: expect 0,0,0,1,2.
      for (int v = 1; v <= 5; v++) cycle(0, 2'b10, 2'b00, DW'(v), '0);
      cycle(0, 2'b11, 2'b00, '0, '0);

      // Output full on flux 0 stalls it; then it resumes without loss.
      for (int k = 0; k < 3; k++) cycle(0, 2'b10, 2'b01, 18'd99, '0);
      cycle(0, 2'b10, 2'b00, 18'd6, '0);
      cycle(0, 2'b10, 2'b00, 18'd7, '0);

      // Mid-stream reset discards history: 7,8,9,6 -> 0,0,0,7.
      cycle(1, 2'b10, 2'b00, '0, '0);
      cycle(0, 2'b10, 2'b00, 18'd7, '0);
      cycle(0, 2'b10, 2'b00, 18'd8, '0);
      cycle(0, 2'b10, 2'b00, 18'd9, '0);
      cycle(0, 2'b10, 2'b00, 18'd6, '0);

      // Both fluxes eligible: arbitration order and lane separation.
      for (int v = 1; v <= 6; v++) cycle(0, 2'b00, 2'b00, DW'(10 * v), DW'(10 * v + 1));

      // Flux 1 alone, ten tokens: pointer wrap and fill saturation.
      for (int v = 1; v <= 10; v++) cycle(0, 2'b01, 2'b00, '0, DW'(v));

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 99) == 0),
               FLUX'($urandom) & FLUX'($urandom),
               FLUX'($urandom) & FLUX'($urandom),
               DW'($urandom), DW'($urandom));
      end

      for (int k = 0; k < 3; k++) cycle(0, 2'b11, 2'b00, '0, '0);
      @(negedge clk);
      mon_en = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: pending=%0d, required 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
